// File: rtl/drap_lsu.sv
// drap_lsu: load/store unit in front of the word-wide DRAP data memory.
// The memory has a 1-cycle registered read.
//
// Requests use a valid/ready handshake. Byte and half stores become a
// read-modify-write of the addressed word. Loads pick out the addressed lane
// and then sign- or zero-extend it. Each request ends with a one-cycle
// response pulse that carries the load data or an error flag.
//
// Optional feature: define DRAP_LSU_BOUNDS_EN to report an error for any
// address above the memory. Left undefined, the upper address bits are
// dropped and the memory aliases.
//
// Ports
//   clk, reset_n          clock, async active-low reset
//   req_valid/req_ready   request handshake; ready only in IDLE
//   req_we, req_size      store/load, 00 byte / 01 half / 10 word / 11 illegal
//   req_unsigned          load extension select
//   req_addr, req_wdata   byte address, right-aligned store data
//   rsp_valid/err/rdata   one-cycle completion pulse with result
//   mem_addr/wdata        word address and write data to memory
//   mem_read/mem_write    memory strobes
//   mem_rdata             memory read data, valid the cycle after mem_read
//
// state | meaning
// IDLE  | waiting for a request; req_ready=1
// READ  | mem_read strobe for the load or RMW word
// MERGE | mem_rdata valid; extract load lane or merge store lane
// WRITE | mem_write strobe, rsp_valid pulse
// RESP  | rsp_valid pulse for loads and errors

module drap_lsu #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [31:0]       rsp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        MERGE = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t              state_q;
    logic                we_q;
    logic [1:0]          size_q;
    logic                uns_q;
    logic [1:0]          lane_q;
    logic [15:0]         wdata_q;
    logic                rsp_valid_q;
    logic                rsp_err_q;
    logic [31:0]         rsp_rdata_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [31:0]         mem_wdata_q;
    logic                mem_read_q;
    logic                mem_write_q;

    logic misalign;
    logic oob;
    logic req_err;

    assign misalign = (req_size == 2'b11)
                    | ((req_size == 2'b01) & req_addr[0])
                    | ((req_size == 2'b10) & (|req_addr[1:0]));

`ifdef DRAP_LSU_BOUNDS_EN
    assign oob = |req_addr[31:ADDR_W+2];
`else
    // The upper address bits are dropped on purpose, so the memory aliases.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];
    assign oob            = 1'b0;
`endif

    assign req_err = misalign | oob;

    // Move the addressed lane down to bit 0, then extend it.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  lane,
                                                 input logic        uns);
        logic [31:0] shifted;
        logic [31:0] res;
        shifted = word >> {lane, 3'b000};
        res     = word;
        case (size)
            2'b00:   res = uns ? {24'h0, shifted[7:0]}
                           : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   res = uns ? {16'h0, shifted[15:0]}
                           : {{16{shifted[15]}}, shifted[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    // Put the store lane into the word that was read; keep all other bytes.
    function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                               input logic [15:0] wdata,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane);
        logic [31:0] mask;
        logic [31:0] data;
        if (size == 2'b00) begin
            mask = 32'h0000_00FF << {lane, 3'b000};
            data = {24'h0, wdata[7:0]} << {lane, 3'b000};
        end else begin
            mask = 32'h0000_FFFF << {lane[1], 4'b0000};
            data = {16'h0, wdata} << {lane[1], 4'b0000};
        end
        return (word & ~mask) | (data & mask);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            lane_q      <= 2'b00;
            wdata_q     <= 16'h0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            // The strobes and the response are single-cycle pulses.
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q       <= req_we;
                        size_q     <= req_size;
                        uns_q      <= req_unsigned;
                        lane_q     <= req_addr[1:0];
                        wdata_q    <= req_wdata[15:0];
                        mem_addr_q <= req_addr[ADDR_W+1:2];
                        if (req_err) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            state_q     <= RESP;
                        end else if (req_we && (req_size == 2'b10)) begin
                            mem_wdata_q <= req_wdata;
                            mem_write_q <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state_q     <= WRITE;
                        end else begin
                            mem_read_q <= 1'b1;
                            state_q    <= READ;
                        end
                    end
                end
                READ: begin
                    state_q <= MERGE;
                end
                MERGE: begin
                    rsp_valid_q <= 1'b1;
                    if (we_q) begin
                        mem_wdata_q <= lane_merge(mem_rdata, wdata_q, size_q, lane_q);
                        mem_write_q <= 1'b1;
                        state_q     <= WRITE;
                    end else begin
                        rsp_rdata_q <= lane_extract(mem_rdata, size_q, lane_q, uns_q);
                        state_q     <= RESP;
                    end
                end
                WRITE:   state_q <= IDLE;
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;

endmodule

// File: tb/tb_drap_lsu.sv
// Testbench for drap_lsu. It includes a behavioural word memory with a
// registered read and a reference memory model. Expected responses and
// memory writes go into queues when each request is accepted. A monitor
// pops them when the DUT produces output.

module tb_drap_lsu;

    localparam int ADDR_W = 4;

    logic              clk;
    logic              reset_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_err;
    logic [31:0]       rsp_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_rdata;

    drap_lsu #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_err      (rsp_err),
        .rsp_rdata    (rsp_rdata),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return 32'h1357_9BDF ^ (i * 32'h0101_0101);
    endfunction

    // Behavioural memory. It is filled on the first clock edge, while reset is held.
    logic [31:0] mem [16];
    logic        mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
            mem_init <= 1'b1;
        end else begin
            if (mem_write) mem[mem_addr] <= mem_wdata;
            if (mem_read)  mem_rdata     <= mem[mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          acc;
        int          lat;
    } exp_t;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;

    exp_t        sbq[$];
    wr_t         wq[$];
    logic [31:0] ref_mem [16];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_rd     = 0;
    int          n_wr     = 0;
    int          exp_rd   = 0;
    int          exp_wr   = 0;
    logic        mon_en   = 1'b1;
    logic [31:0] last_rdata = 32'h0;
    logic [31:0] last_wdata = 32'h0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && reset_n) begin
            if (mem_read) n_rd++;
            if (mem_write) begin
                n_wr++;
                last_wdata = mem_wdata;
                if (wq.size() == 0) begin
                    check("wr_unexpected", 1, 0);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    check("wr_addr", mem_addr, w.addr);
                    check("wr_data", mem_wdata, w.data);
                end
            end
            if (rsp_valid) begin
                last_rdata = rsp_rdata;
                if (sbq.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("rsp_err", rsp_err, e.err);
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_latency", cyc - e.acc + 1, e.lat);
                end
            end
        end
    end

    // Drive one request, wait for it to be accepted, and queue its expected results.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd);
        exp_t        e;
        wr_t         w;
        logic [31:0] word;
        logic [7:0]  b;
        logic [15:0] h;
        logic        err;
        int          idx;
        int          guard;
        @(negedge clk);
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        req_valid    = 1'b1;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            check("accept_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        idx  = int'(addr[5:2]);
        word = ref_mem[idx];
        err  = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00);
`ifdef DRAP_LSU_BOUNDS_EN
        if (addr[31:6] != 26'h0) err = 1'b1;
`endif
        e.acc   = cyc + 1;
        e.err   = err;
        e.rdata = 32'h0;
        if (err) begin
            e.lat = 1;
        end else if (we) begin
            case (sz)
                2'b00:   word[8*addr[1:0] +: 8]  = wd[7:0];
                2'b01:   word[16*addr[1] +: 16]  = wd[15:0];
                default: word                    = wd;
            endcase
            ref_mem[idx] = word;
            w.addr = addr[5:2];
            w.data = word;
            wq.push_back(w);
            exp_wr++;
            if (sz != 2'b10) exp_rd++;
            e.lat = (sz == 2'b10) ? 1 : 3;
        end else begin
            b = word[8*addr[1:0] +: 8];
            h = word[16*addr[1] +: 16];
            case (sz)
                2'b00:   e.rdata = uns ? {24'h0, b} : {{24{b[7]}}, b};
                2'b01:   e.rdata = uns ? {16'h0, h} : {{16{h[15]}}, h};
                default: e.rdata = word;
            endcase
            exp_rd++;
            e.lat = 3;
        end
        sbq.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((sbq.size() != 0 || wq.size() != 0 || !req_ready) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("idle_timeout", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        int rd0;
        int wr0;
        int guard;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        reset_n      = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Word store, then a word load from the same address.
        do_req(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEAD_BEEF);
        do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        wait_idle();
        check("t2_lw", last_rdata, 32'hDEAD_BEEF);

        // Byte store merged into the stored word.
        do_req(1'b1, 2'b00, 1'b0, 32'h9, 32'h0000_0055);
        wait_idle();
        check("t3_merge", last_wdata, 32'hDEAD_55EF);

        do_req(1'b0, 2'b00, 1'b0, 32'hB, 32'h0);
        wait_idle();
        check("t4_lb", last_rdata, 32'hFFFF_FFDE);
        do_req(1'b0, 2'b00, 1'b1, 32'hB, 32'h0);
        wait_idle();
        check("t4_lbu", last_rdata, 32'h0000_00DE);
        do_req(1'b0, 2'b01, 1'b0, 32'hA, 32'h0);
        wait_idle();
        check("t4_lh", last_rdata, 32'hFFFF_DEAD);

        // Reset asserted during the WRITE of a byte store aborts the store.
        mon_en = 1'b0;
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h9; req_wdata = 32'h77; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        guard = 0;
        while (!mem_write && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("t1_reached_write", mem_write, 1);
        reset_n = 1'b0;
        #1;
        check("t1_mem_write", mem_write, 0);
        check("t1_ready", req_ready, 1);
        check("t1_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        wait_idle();
        check("t1_word_kept", last_rdata, 32'hDEAD_55EF);

        // Misaligned and illegal requests never strobe the memory.
        rd0 = n_rd;
        wr0 = n_wr;
        do_req(1'b0, 2'b01, 1'b0, 32'h3, 32'h0);
        do_req(1'b1, 2'b10, 1'b0, 32'h6, 32'h1234_5678);
        do_req(1'b0, 2'b11, 1'b0, 32'h4, 32'h0);
        do_req(1'b1, 2'b11, 1'b1, 32'h0, 32'h0);
        wait_idle();
        check("t5_no_read", n_rd, rd0);
        check("t5_no_write", n_wr, wr0);

        // Out-of-range address: an error with bounds checking, otherwise an alias of word 0.
        do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        wait_idle();

        for (int i = 0; i < 80; i++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) a = a | 32'h0000_0400;
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), a, $urandom);
        end
        wait_idle();

        check("end_rsp_queue", sbq.size(), 0);
        check("end_wr_queue", wq.size(), 0);
        check("end_read_count", n_rd, exp_rd);
        check("end_write_count", n_wr, exp_wr);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
